// File: rtl/game_controller.sv
// Top-level game sequencer: stages, lives with respawn delay, pause, saturating score
// and a high score that only resetN clears.
module game_controller #(
  parameter int unsigned NUM_ENEMY       = 15,
  parameter int unsigned NUM_STAGES      = 4,
  parameter int unsigned STAGE_W         = 3,
  parameter int unsigned LIVES           = 3,
  parameter int unsigned SCORE_W         = 14,
  parameter int unsigned POINTS_PER_KILL = 10,
  parameter int unsigned CLEAR_DELAY     = 64,
  parameter int unsigned RESPAWN_DELAY   = 32
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 tick,
  input  logic                 btnStart,
  input  logic                 btnPause,
  input  logic [NUM_ENEMY-1:0] enemyAlive,
  input  logic [NUM_ENEMY-1:0] enemyKill,
  input  logic                 playerHit,
  output logic [2:0]           gameState,
  output logic [STAGE_W-1:0]   stage,
  output logic [2:0]           lives,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   highScore,
  output logic                 stageLoad,
  output logic                 playerRespawn,
  output logic                 freeze
);

  localparam int unsigned MAX_DELAY = (CLEAR_DELAY > RESPAWN_DELAY) ? CLEAR_DELAY : RESPAWN_DELAY;
  localparam int unsigned TIMER_W   = $clog2(MAX_DELAY + 1);
  localparam int unsigned CNT_W     = $clog2(NUM_ENEMY + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PLAYING     = 3'd1,
    S_VICTORY     = 3'd2,
    S_DEFEAT      = 3'd3,
    S_PAUSED      = 3'd4,
    S_STAGE_CLEAR = 3'd5,
    S_RESPAWN     = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [2:0]           lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 load_q, load_d;
  logic                 respawn_q, respawn_d;
  logic                 freeze_q, freeze_d;
  logic                 start_prev_q, pause_prev_q;
  logic                 start_pend_q, start_pend_d;
  logic                 pause_pend_q, pause_pend_d;
  logic                 hit_pend_q, hit_pend_d;

  logic                 start_evt, pause_evt, hit_evt;
  logic [CNT_W-1:0]     kill_cnt;
  logic [31:0]          score_sum;

  // Registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      stage_q      <= '0;
      lives_q      <= '0;
      score_q      <= '0;
      high_q       <= '0;
      timer_q      <= '0;
      load_q       <= 1'b0;
      respawn_q    <= 1'b0;
      freeze_q     <= 1'b1;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      start_pend_q <= 1'b0;
      pause_pend_q <= 1'b0;
      hit_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      high_q       <= high_d;
      timer_q      <= timer_d;
      load_q       <= load_d;
      respawn_q    <= respawn_d;
      freeze_q     <= freeze_d;
      start_prev_q <= btnStart;
      pause_prev_q <= btnPause;
      start_pend_q <= start_pend_d;
      pause_pend_q <= pause_pend_d;
      hit_pend_q   <= hit_pend_d;
    end
  end

  // Next-state, scoring and pulse generation
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    lives_d   = lives_q;
    score_d   = score_q;
    high_d    = high_q;
    timer_d   = timer_q;
    load_d    = 1'b0;
    respawn_d = 1'b0;

    // Edges arriving on the tick clock itself count for that tick
    start_evt = start_pend_q | (btnStart & ~start_prev_q);
    pause_evt = pause_pend_q | (btnPause & ~pause_prev_q);
    hit_evt   = hit_pend_q | (playerHit & (state_q == S_PLAYING));

    start_pend_d = tick ? 1'b0 : start_evt;
    pause_pend_d = tick ? 1'b0 : pause_evt;
    hit_pend_d   = tick ? 1'b0 : hit_evt;

    kill_cnt = '0;
    for (int i = 0; i < int'(NUM_ENEMY); i++) begin
      kill_cnt = kill_cnt + CNT_W'(enemyKill[i]);
    end
    score_sum = 32'(score_q) + 32'(POINTS_PER_KILL) * 32'(kill_cnt);
    if (state_q == S_PLAYING) begin
      score_d = (score_sum > 32'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(score_sum);
    end

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (start_evt) begin
            state_d = S_PLAYING;
            stage_d = '0;
            lives_d = 3'(LIVES);
            score_d = '0;
            load_d  = 1'b1;
          end
        end
        S_PLAYING: begin
          if (start_evt) begin
            state_d = S_IDLE;
          end else if (hit_evt) begin
            lives_d = lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_d = S_DEFEAT;
              if (score_d > high_q) high_d = score_d;
            end else begin
              state_d = S_RESPAWN;
              timer_d = TIMER_W'(RESPAWN_DELAY);
            end
          end else if (enemyAlive == '0) begin
            if (stage_q == STAGE_W'(NUM_STAGES - 1)) begin
              state_d = S_VICTORY;
              if (score_d > high_q) high_d = score_d;
            end else begin
              state_d = S_STAGE_CLEAR;
              timer_d = TIMER_W'(CLEAR_DELAY);
            end
          end else if (pause_evt) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (start_evt)      state_d = S_IDLE;
          else if (pause_evt) state_d = S_PLAYING;
        end
        S_STAGE_CLEAR: begin
          timer_d = timer_q - TIMER_W'(1);
          if (timer_q <= TIMER_W'(1)) begin
            timer_d = '0;
            stage_d = stage_q + STAGE_W'(1);
            load_d  = 1'b1;
            state_d = S_PLAYING;
          end
        end
        S_RESPAWN: begin
          timer_d = timer_q - TIMER_W'(1);
          if (timer_q <= TIMER_W'(1)) begin
            timer_d   = '0;
            respawn_d = 1'b1;
            state_d   = S_PLAYING;
          end
        end
        S_VICTORY, S_DEFEAT: begin
          if (start_evt) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    freeze_d = (state_d != S_PLAYING);
  end

  assign gameState     = state_q;
  assign stage         = stage_q;
  assign lives         = lives_q;
  assign score         = score_q;
  assign highScore     = high_q;
  assign stageLoad     = load_q;
  assign playerRespawn = respawn_q;
  assign freeze        = freeze_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: stimulus queues each expected output snapshot,
// a monitor pops one whenever the DUT's output vector changes.
module tb_game_controller;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  stg;
    logic [2:0]  lv;
    logic [13:0] sc;
    logic [13:0] hs;
    logic        sl;
    logic        pr;
    logic        fz;
  } snap_t;

  logic        clock = 1'b0;
  logic        resetN = 1'b1;
  logic        tick = 1'b0;
  logic        btnStart = 1'b0;
  logic        btnPause = 1'b0;
  logic [14:0] enemyAlive = '1;
  logic [14:0] enemyKill = '0;
  logic        playerHit = 1'b0;
  logic [2:0]  gameState;
  logic [2:0]  stage;
  logic [2:0]  lives;
  logic [13:0] score;
  logic [13:0] highScore;
  logic        stageLoad;
  logic        playerRespawn;
  logic        freeze;

  int checks = 0;
  int errors = 0;
  snap_t exp_q[$];
  string name_q[$];
  snap_t e;

  game_controller dut (
    .clock(clock), .resetN(resetN), .tick(tick), .btnStart(btnStart), .btnPause(btnPause),
    .enemyAlive(enemyAlive), .enemyKill(enemyKill), .playerHit(playerHit),
    .gameState(gameState), .stage(stage), .lives(lives), .score(score),
    .highScore(highScore), .stageLoad(stageLoad), .playerRespawn(playerRespawn),
    .freeze(freeze)
  );

  always #5 clock = ~clock;

  task automatic push(input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic clk(input logic t);
    tick = t;
    @(posedge clock);
    #1;
    tick = 1'b0;
    enemyKill = '0;
    playerHit = 1'b0;
  endtask

  task automatic press_start();
    btnStart = 1'b1;
    clk(1'b0);
    btnStart = 1'b0;
  endtask

  task automatic press_pause();
    btnPause = 1'b1;
    clk(1'b0);
    btnPause = 1'b0;
  endtask

  task automatic begin_game(input string n);
    press_start();
    e.st = 3'd1; e.stg = 3'd0; e.lv = 3'd3; e.sc = 14'd0; e.sl = 1'b1; e.fz = 1'b0;
    push(n);
    clk(1'b1);
    e.sl = 1'b0;
    push({n, "_load_end"});
    clk(1'b0);
  endtask

  // Monitor: any change of the output vector consumes one expected snapshot
  initial begin
    snap_t cur, prev, ex;
    string nm;
    bit first;
    first = 1'b1;
    prev = '0;
    forever begin
      @(negedge clock);
      cur = {gameState, stage, lives, score, highScore, stageLoad, playerRespawn, freeze};
      if (first || cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change at %0t: got st=%0d stg=%0d lv=%0d sc=%0d hs=%0d sl=%0b pr=%0b fz=%0b",
                   $time, cur.st, cur.stg, cur.lv, cur.sc, cur.hs, cur.sl, cur.pr, cur.fz);
        end else begin
          ex = exp_q.pop_front();
          nm = name_q.pop_front();
          if (cur !== ex) begin
            errors++;
            $display("FAIL %s at %0t: got st=%0d stg=%0d lv=%0d sc=%0d hs=%0d sl=%0b pr=%0b fz=%0b, want st=%0d stg=%0d lv=%0d sc=%0d hs=%0d sl=%0b pr=%0b fz=%0b",
                     nm, $time, cur.st, cur.stg, cur.lv, cur.sc, cur.hs, cur.sl, cur.pr, cur.fz,
                     ex.st, ex.stg, ex.lv, ex.sc, ex.hs, ex.sl, ex.pr, ex.fz);
          end
        end
        prev = cur;
        first = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    e = '{st: 3'd0, stg: 3'd0, lv: 3'd0, sc: 14'd0, hs: 14'd0, sl: 1'b0, pr: 1'b0, fz: 1'b1};
    push("reset");
    #2 resetN = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    clk(1'b0);

    // Game A: score, pause, respawns, simultaneous hit/clear, defeat
    begin_game("start_a");
    enemyKill = 15'h0007;
    e.sc = 14'd30; push("kill3");
    clk(1'b0);
    press_pause();
    e.st = 3'd4; e.fz = 1'b1; push("pause");
    clk(1'b1);
    enemyKill = '1;
    clk(1'b0);
    btnPause = 1'b1;
    e.st = 3'd1; e.fz = 1'b0; push("resume_same_clock_edge");
    clk(1'b1);
    btnPause = 1'b0;
    clk(1'b0);
    playerHit = 1'b1;
    clk(1'b0);
    e.st = 3'd6; e.lv = 3'd2; e.fz = 1'b1; push("hit1_latched");
    clk(1'b1);
    for (int i = 0; i < 31; i++) clk(1'b1);
    e.st = 3'd1; e.pr = 1'b1; e.fz = 1'b0; push("respawn1");
    clk(1'b1);
    e.pr = 1'b0; push("respawn1_end");
    clk(1'b0);
    playerHit = 1'b1;
    enemyAlive = '0;
    e.st = 3'd6; e.lv = 3'd1; e.fz = 1'b1; push("hit_beats_clear");
    clk(1'b1);
    enemyAlive = '1;
    for (int i = 0; i < 31; i++) clk(1'b1);
    e.st = 3'd1; e.pr = 1'b1; e.fz = 1'b0; push("respawn2");
    clk(1'b1);
    e.pr = 1'b0; push("respawn2_end");
    clk(1'b0);
    playerHit = 1'b1;
    e.st = 3'd3; e.lv = 3'd0; e.hs = 14'd30; e.fz = 1'b1; push("defeat");
    clk(1'b1);
    enemyKill = '1;
    clk(1'b1);
    press_start();
    e.st = 3'd0; push("defeat_to_idle");
    clk(1'b1);

    // Game C: stop from PAUSED keeps the high score
    begin_game("start_c");
    enemyKill = '1;
    e.sc = 14'd150; push("kill15");
    clk(1'b0);
    press_pause();
    e.st = 3'd4; e.fz = 1'b1; push("pause_c");
    clk(1'b1);
    press_start();
    e.st = 3'd0; push("stop_from_pause");
    clk(1'b1);

    // Game B: saturation and full stage progression to victory
    begin_game("start_b");
    sc = 0;
    for (int i = 0; i < 110; i++) begin
      sc = (sc + 150 > 16383) ? 16383 : sc + 150;
      enemyKill = '1;
      e.sc = 14'(sc); push("score_ramp");
      clk(1'b0);
    end
    enemyKill = '1;
    clk(1'b0);
    for (int s = 0; s < 4; s++) begin
      enemyAlive = '0;
      if (s == 3) begin
        e.st = 3'd2; e.hs = 14'd16383; e.fz = 1'b1; push("victory");
        clk(1'b1);
        enemyAlive = '1;
      end else begin
        e.st = 3'd5; e.fz = 1'b1; push("stage_clear");
        clk(1'b1);
        enemyAlive = '1;
        for (int i = 0; i < 63; i++) clk(1'b1);
        e.st = 3'd1; e.stg = 3'(s + 1); e.sl = 1'b1; e.fz = 1'b0; push("next_stage");
        clk(1'b1);
        e.sl = 1'b0; push("next_stage_load_end");
        clk(1'b0);
      end
    end
    press_start();
    e.st = 3'd0; push("victory_to_idle");
    clk(1'b1);

    // Game D: reset in the middle of RESPAWN
    begin_game("start_d");
    playerHit = 1'b1;
    e.st = 3'd6; e.lv = 3'd2; e.fz = 1'b1; push("hit_d");
    clk(1'b1);
    repeat (5) clk(1'b1);
    e = '{st: 3'd0, stg: 3'd0, lv: 3'd0, sc: 14'd0, hs: 14'd0, sl: 1'b0, pr: 1'b0, fz: 1'b1};
    push("mid_game_reset");
    resetN = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    repeat (4) clk(1'b1);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected snapshots never observed, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
